// File: rtl/mul_div_unit.sv
// EX-stage multiply/divide unit: MULT/MULTU/DIV/DIVU with a fixed Busy latency into HI/LO, plus MTHI/MTLO.
// The result is computed in the Start cycle and held in temps until the latency counter expires.
module mul_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  MDOp,
   input  logic        Start,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW   = $clog2(MAXC + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          r_state, w_state_nxt;
   logic [CW-1:0]   r_cnt;
   logic [31:0]     r_hi_tmp, r_lo_tmp;
   logic            r_wr;

   logic            w_accept, w_is_mul, w_is_div, w_launch, w_done;
   logic [63:0]     w_prod_s, w_prod_u;
   logic [31:0]     w_b_safe, w_a_mag, w_b_mag;
   logic [31:0]     w_qu, w_ru, w_qm, w_rm, w_qs, w_rs;
   logic [31:0]     w_hi_res, w_lo_res;
   logic            w_wr_res;

   assign w_accept = Start && (r_state == IDLE);
   assign w_is_mul = (MDOp == 3'd1) || (MDOp == 3'd2);
   assign w_is_div = (MDOp == 3'd3) || (MDOp == 3'd4);
   assign w_launch = w_accept && (w_is_mul || w_is_div);
   assign w_done   = (r_state == RUN) && (r_cnt == CW'(1));

   assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign w_prod_u = {32'd0, A} * {32'd0, B};

   // Signed divide via magnitudes: avoids the MIN_INT / -1 overflow case of a native signed divide.
   assign w_b_safe = (B == '0) ? 32'd1 : B;
   assign w_a_mag  = A[31] ? (32'd0 - A) : A;
   assign w_b_mag  = w_b_safe[31] ? (32'd0 - w_b_safe) : w_b_safe;
   assign w_qu     = A / w_b_safe;
   assign w_ru     = A % w_b_safe;
   assign w_qm     = w_a_mag / w_b_mag;
   assign w_rm     = w_a_mag % w_b_mag;
   assign w_qs     = (A[31] ^ w_b_safe[31]) ? (32'd0 - w_qm) : w_qm;
   assign w_rs     = A[31] ? (32'd0 - w_rm) : w_rm;

   always_comb begin
      w_hi_res = '0;
      w_lo_res = '0;
      w_wr_res = 1'b1;
      case (MDOp)
         3'd1: {w_hi_res, w_lo_res} = w_prod_s;
         3'd2: {w_hi_res, w_lo_res} = w_prod_u;
         3'd3: begin
            w_hi_res = w_rs;
            w_lo_res = w_qs;
            w_wr_res = (B != '0);
         end
         3'd4: begin
            w_hi_res = w_ru;
            w_lo_res = w_qu;
            w_wr_res = (B != '0);
         end
         default: w_wr_res = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_launch) w_state_nxt = RUN;
         RUN:     if (w_done)   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      Busy = (r_state == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_hi_tmp <= '0;
         r_lo_tmp <= '0;
         r_wr     <= 1'b0;
      end else if (w_launch) begin
         r_cnt    <= w_is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
         r_hi_tmp <= w_hi_res;
         r_lo_tmp <= w_lo_res;
         r_wr     <= w_wr_res;
      end else if (r_state == RUN) begin
         r_cnt    <= r_cnt - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         HI <= '0;
         LO <= '0;
      end else if (w_done) begin
         if (r_wr) begin
            HI <= r_hi_tmp;
            LO <= r_lo_tmp;
         end
      end else if (w_accept && (MDOp == 3'd5)) begin
         HI <= A;
      end else if (w_accept && (MDOp == 3'd6)) begin
         LO <= A;
      end
   end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random operations against an arithmetic model of HI/LO.
module tb_mul_div_unit;

   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] A = '0, B = '0;
   logic [2:0]  MDOp = '0;
   logic        Start = 1'b0;
   logic        Busy;
   logic [31:0] HI, LO;

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;
   logic [31:0] m_hi = '0, m_lo = '0;

   mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .rst_n(rst_n), .A(A), .B(B), .MDOp(MDOp),
      .Start(Start), .Busy(Busy), .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Issues one op; inj>0 fires an MTHI 0x55 at that Busy cycle (must be ignored).
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned inj);
      logic [31:0] e_hi, e_lo;
      logic [63:0] p;
      longint      sa, sb, q, r;
      int unsigned n_exp, cnt;
      e_hi = m_hi; e_lo = m_lo; n_exp = 0;
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      case (op)
         3'd1: begin p = 64'(sa * sb); {e_hi, e_lo} = p; n_exp = MC; end
         3'd2: begin p = {32'd0, a} * {32'd0, b}; {e_hi, e_lo} = p; n_exp = MC; end
         3'd3: begin
            n_exp = DC;
            if (b != 0) begin q = sa / sb; r = sa % sb; e_lo = q[31:0]; e_hi = r[31:0]; end
         end
         3'd4: begin
            n_exp = DC;
            if (b != 0) begin e_lo = a / b; e_hi = a % b; end
         end
         3'd5: e_hi = a;
         3'd6: e_lo = a;
         default: ;
      endcase
      @(negedge clk);
      Start = 1'b1; MDOp = op; A = a; B = b;
      @(negedge clk);
      Start = 1'b0; A = $urandom; B = $urandom; MDOp = 3'($urandom);
      if (n_exp == 0) begin
         chk("busy_idle", 32'(Busy), 32'd0);
      end else begin
         cnt = 0;
         while (Busy && cnt < 100) begin
            cnt++;
            if (cnt == 1) begin
               chk("hold_hi", HI, m_hi);
               chk("hold_lo", LO, m_lo);
            end
            if (cnt == inj) begin
               Start = 1'b1; MDOp = 3'd5; A = 32'h55;
            end else begin
               Start = 1'b0; A = $urandom; B = $urandom;
            end
            @(negedge clk);
         end
         Start = 1'b0;
         chk("busy_len", cnt, n_exp);
      end
      chk("hi", HI, e_hi);
      chk("lo", LO, e_lo);
      m_hi = e_hi; m_lo = e_lo;
   endtask

   initial begin
      int unsigned cnt;
      logic [2:0]  op;
      logic [31:0] a, b;
      #12;
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_hi", HI, 32'd0);
      chk("rst_lo", LO, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      do_op(3'd1, 32'hFFFFFFFD, 32'd5, 0);
      chk("t1_hi", HI, 32'hFFFFFFFF);
      chk("t1_lo", LO, 32'hFFFFFFF1);
      do_op(3'd2, 32'hFFFFFFFF, 32'd2, 0);
      chk("t2_hi", HI, 32'h00000001);
      chk("t2_lo", LO, 32'hFFFFFFFE);
      do_op(3'd3, 32'hFFFFFFF9, 32'd2, 0);
      chk("t3_lo", LO, 32'hFFFFFFFD);
      chk("t3_hi", HI, 32'hFFFFFFFF);
      do_op(3'd4, 32'hFFFFFFF9, 32'd2, 0);
      chk("t3u_lo", LO, 32'h7FFFFFFC);
      chk("t3u_hi", HI, 32'h00000001);
      do_op(3'd5, 32'hAA, 32'd0, 0);
      do_op(3'd6, 32'hBB, 32'd0, 0);
      do_op(3'd4, 32'h1234, 32'd0, 0);
      chk("t4_hi", HI, 32'hAA);
      chk("t4_lo", LO, 32'hBB);
      do_op(3'd3, 32'h80000000, 32'hFFFFFFFF, 0);
      chk("ovf_lo", LO, 32'h80000000);
      chk("ovf_hi", HI, 32'h0);
      do_op(3'd1, 32'h00012345, 32'h00000777, 2);
      do_op(3'd5, 32'h55, 32'd0, 0);
      chk("t5_hi", HI, 32'h55);
      do_op(3'd0, 32'h1, 32'h1, 0);
      do_op(3'd7, 32'h2, 32'h2, 0);

      // DIV in flight, asynchronous reset between clock edges at Busy cycle 4
      @(negedge clk);
      Start = 1'b1; MDOp = 3'd3; A = 32'd1000; B = 32'd7;
      @(negedge clk);
      Start = 1'b0;
      cnt = 1;
      while (cnt < 4) begin @(negedge clk); cnt++; end
      chk("t6_busy_pre", 32'(Busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_busy", 32'(Busy), 32'd0);
      chk("t6_hi", HI, 32'd0);
      chk("t6_lo", LO, 32'd0);
      m_hi = '0; m_lo = '0;
      @(negedge clk); rst_n = 1'b1;
      do_op(3'd1, 32'd3, 32'd4, 0);
      chk("t6_mul_lo", LO, 32'd12);
      chk("t6_mul_hi", HI, 32'd0);

      for (int i = 0; i < 60; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 7))
            0: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            1: b = '0;
            2: b = 32'($urandom_range(1, 16));
            3: a = 32'($urandom_range(0, 255));
            default: ;
         endcase
         do_op(op, a, b, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
